enc16_rr: RTL and testbench
===========================

// Module: enc16_rr
// PURPOSE
//  Registered 16-to-4 request encoder: inverse of the 4-to-16 decoder path. Latches one-hot/multi-hot
//  request lines into a pending mask and issues the 4-bit index of each pending line, one per handshake,
//  with round-robin (or fixed) priority. Used to turn 16 line requests (e.g. register/unit select
//  strobes) back into an encoded index for the multicycle datapath control.
// PARAMETERS
//  N    16  number of request lines (spec and tests fixed at 16)
//  IW   4   index width, log2(N)
//  RR   1   1 = round-robin priority from rotating pointer; 0 = fixed priority, line 0 highest
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  en         in   1   capture enable; req sampled only when en=1
//  req        in   16  request lines, bit i = request for index i
//  out_ready  in   1   consumer accepts out_idx this cycle
//  out_valid  out  1   out_idx holds a valid issued index
//  out_idx    out  4   encoded index of issued line
//  pending    out  16  current pending mask (includes the issued-but-unaccepted line)
//  busy       out  1   out_valid | (|pending)
// BEHAVIOUR
//  Reset (rst=1 at edge): pending=0, out_valid=0, out_idx=0, ptr=0; busy=0. Overrides en/req/out_ready;
//   reset mid-operation discards all pending and issued requests, no index emitted afterwards.
//  Handshake: fire = out_valid & out_ready. served = fire ? onehot(out_idx) : 0.
//  Pending update each edge: pending <= (pending & ~served) | (en ? req : 0). Set wins over clear:
//   a line re-requested in the cycle it is served stays pending and is issued again later.
//  en=0: req ignored entirely.
//  States (encoded by out_valid): IDLE (out_valid=0), ISSUE (out_valid=1).
//   cand = pending & ~served (uses registered pending, not this cycle's req).
//   IDLE: if |cand -> load sel(cand), go ISSUE; else stay IDLE.
//   ISSUE & !out_ready: hold; out_idx, out_valid stable (no re-selection, even if higher-priority lines arrive).
//   ISSUE & out_ready: if |cand -> load next sel(cand), stay ISSUE (back-to-back, 1 index/cycle);
//    else -> IDLE, out_valid=0, out_idx keeps last value.
//  sel(): RR=1 -> first set bit scanning ptr, ptr+1, ... wrapping 15->0; RR=0 -> lowest set bit.
//  ptr: on each load with RR=1, ptr <= (loaded idx + 1) mod 16 (15 wraps to 0); RR=0 ptr stays 0.
//  Latency: req with en=1 at edge k -> pending bit set after k -> out_valid/out_idx earliest after k+1.
//  Throughput: with out_ready=1 and pending nonempty, one index accepted per cycle, no bubble.
//  Width rules: out_idx is IW bits, no overflow; pending never holds bits outside [15:0].
//  req=0 with en=1 is a no-op. All outputs registered except busy (combinational from registers).
// TESTING
//  1 Reset: rst=1 2 cycles with req=FFFF,en=1 -> out_valid=0,out_idx=0,pending=0,busy=0 after.
//  2 Single: en=1,req=0020 for 1 cycle,out_ready=1 -> pending=0020 next cycle; out_valid=1,out_idx=5 one
//    cycle later for exactly 1 cycle; then pending=0,busy=0.
//  3 RR sweep: RR=1, en pulse req=8101, out_ready=1 -> idx 0,8,15 on consecutive cycles; ptr ends 0.
//  4 Backpressure: req=0006, out_ready=0 4 cycles -> out_idx=1 valid & stable, pending=0006;
//    then out_ready=1 -> idx 1 then 2, then out_valid=0.
//  5 Collision: pending=0018,ptr=3, idx 3 issued, out_ready=1 and en=1,req=0008 same cycle -> next idx 4,
//    then idx 3 again; pending=0 after; also en=0,req=FFFF for 5 cycles -> no change.
//  6 Reset mid-op: pending=00F0,out_valid=1,out_ready=0, rst=1 1 cycle -> all cleared, no index issued
//    after; RR=0 build: req=0009 -> idx 0 then 3.

Source files
------------

// File: rtl/enc16_rr.sv
// Registered 16-to-4 request encoder: latches request lines into a pending
// mask and issues one encoded index per handshake, round-robin or fixed priority.
module enc16_rr #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4,
  parameter int unsigned RR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  pending,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nx;
  logic [IW-1:0] idx_nx;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  served;
  logic [N-1:0]  cand;
  logic [N-1:0]  pending_nx;
  logic          fire;
  logic          load;

  // The FSM state register doubles as the valid flag.
  assign out_valid = (state == ISSUE);
  assign busy      = out_valid | (|pending);

  // The accepted line drops out of the candidate set this cycle.
  assign fire   = out_valid & out_ready;
  assign served = fire ? (N'(1) << out_idx) : '0;
  assign cand   = pending & ~served;

  // Priority pick: scan from ptr with wrap (round-robin) or from line 0 (fixed).
  always_comb begin
    logic [IW-1:0] pos;
    logic          found;
    sel_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (RR != 0) ? IW'(ptr + IW'(i)) : IW'(i);
      if (!found && cand[pos]) begin
        sel_idx = pos;
        found   = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; held index is never re-selected under backpressure.
  always_comb begin
    state_nx   = state;
    idx_nx     = out_idx;
    ptr_nx     = ptr;
    load       = 1'b0;
    pending_nx = cand | (en ? req : '0);
    case (state)
      IDLE: begin
        if (|cand) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (|cand) load = 1'b1;
          else       state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      idx_nx = sel_idx;
      if (RR != 0) ptr_nx = IW'(sel_idx + IW'(1));
    end
  end

  // State, index, pointer and pending registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out_idx <= '0;
      ptr     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      out_idx <= idx_nx;
      ptr     <= ptr_nx;
      pending <= pending_nx;
    end
  end

endmodule

// File: tb/tb_enc16_rr.sv
// Directed self-checking bench for enc16_rr (round-robin and fixed-priority builds).
module tb_enc16_rr;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        out_ready;

  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] pending;
  logic        busy;

  logic        fx_valid;
  logic [3:0]  fx_idx;
  logic [15:0] fx_pending;
  logic        fx_busy;

  int compared;
  int mismatched;

  enc16_rr #(.N(16), .IW(4), .RR(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .busy(busy)
  );

  enc16_rr #(.N(16), .IW(4), .RR(0)) dut_fx (
    .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(fx_valid), .out_idx(fx_idx), .pending(fx_pending), .busy(fx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] i, input logic [15:0] p);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".idx"}, 32'(out_idx), 32'(i));
    check({tag, ".pending"}, 32'(pending), 32'(p));
    check({tag, ".busy"}, 32'(busy), 32'(v | (|p)));
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;
    #2;

    // 1: reset overrides en/req
    rst = 1'b1; en = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    step();
    chk_out("rst_c1", 1'b0, 4'd0, 16'h0000);
    step();
    chk_out("rst_c2", 1'b0, 4'd0, 16'h0000);
    rst = 1'b0; en = 1'b0; req = '0;
    step();
    chk_out("rst_after", 1'b0, 4'd0, 16'h0000);

    // 2: single request, latency and one-cycle issue
    do_reset();
    out_ready = 1'b1; en = 1'b1; req = 16'h0020;
    step();
    chk_out("single_pend", 1'b0, 4'd0, 16'h0020);
    en = 1'b0; req = '0;
    step();
    chk_out("single_issue", 1'b1, 4'd5, 16'h0020);
    step();
    chk_out("single_done", 1'b0, 4'd5, 16'h0000);

    // 3: round-robin sweep over 0,8,15 with pointer wrapping back to 0
    do_reset();
    out_ready = 1'b1; en = 1'b1; req = 16'h8101;
    step();
    en = 1'b0; req = '0;
    chk_out("rr_pend", 1'b0, 4'd0, 16'h8101);
    step();
    chk_out("rr_i0", 1'b1, 4'd0, 16'h8101);
    step();
    chk_out("rr_i8", 1'b1, 4'd8, 16'h8100);
    step();
    chk_out("rr_i15", 1'b1, 4'd15, 16'h8000);
    step();
    chk_out("rr_idle", 1'b0, 4'd15, 16'h0000);
    en = 1'b1; req = 16'h0003;
    step();
    en = 1'b0; req = '0;
    step();
    chk_out("rr_ptr0", 1'b1, 4'd0, 16'h0003);
    step();
    chk_out("rr_ptr1", 1'b1, 4'd1, 16'h0002);
    step();
    chk_out("rr_ptr_idle", 1'b0, 4'd1, 16'h0000);

    // 4: backpressure holds index stable
    do_reset();
    out_ready = 1'b0; en = 1'b1; req = 16'h0006;
    step();
    en = 1'b0; req = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("bp_hold%0d", c), 1'b1, 4'd1, 16'h0006);
    end
    out_ready = 1'b1;
    step();
    chk_out("bp_i2", 1'b1, 4'd2, 16'h0004);
    step();
    chk_out("bp_idle", 1'b0, 4'd2, 16'h0000);

    // 5: re-request of the served line wins over clear
    do_reset();
    out_ready = 1'b0; en = 1'b1; req = 16'h0018;
    step();
    en = 1'b0; req = '0;
    step();
    chk_out("col_i3", 1'b1, 4'd3, 16'h0018);
    out_ready = 1'b1; en = 1'b1; req = 16'h0008;
    step();
    en = 1'b0; req = '0;
    chk_out("col_i4", 1'b1, 4'd4, 16'h0018);
    step();
    chk_out("col_i3b", 1'b1, 4'd3, 16'h0008);
    step();
    chk_out("col_idle", 1'b0, 4'd3, 16'h0000);
    en = 1'b0; req = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out($sformatf("en0_c%0d", c), 1'b0, 4'd3, 16'h0000);
    end
    req = '0;

    // 6: reset mid-operation discards everything
    do_reset();
    out_ready = 1'b0; en = 1'b1; req = 16'h00F0;
    step();
    en = 1'b0; req = '0;
    step();
    chk_out("mid_issue", 1'b1, 4'd4, 16'h00F0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("mid_rst", 1'b0, 4'd0, 16'h0000);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out($sformatf("mid_quiet%0d", c), 1'b0, 4'd0, 16'h0000);
    end

    // 6b: fixed-priority build versus round-robin build
    do_reset();
    out_ready = 1'b1; en = 1'b1; req = 16'h0009;
    step();
    en = 1'b0; req = '0;
    step();
    check("fx_a0.valid", 32'(fx_valid), 32'd1);
    check("fx_a0.idx", 32'(fx_idx), 32'd0);
    step();
    check("fx_a3.idx", 32'(fx_idx), 32'd3);
    check("fx_a3.pending", 32'(fx_pending), 32'h0008);
    step();
    check("fx_a_idle.valid", 32'(fx_valid), 32'd0);
    check("fx_a_idle.busy", 32'(fx_busy), 32'd0);
    en = 1'b1; req = 16'h0012;
    step();
    en = 1'b0; req = '0;
    step();
    check("fx_b1.idx", 32'(fx_idx), 32'd1);
    check("rr_b4.idx", 32'(out_idx), 32'd4);
    step();
    check("fx_b4.idx", 32'(fx_idx), 32'd4);
    check("rr_b1.idx", 32'(out_idx), 32'd1);
    step();
    check("fx_b_idle.valid", 32'(fx_valid), 32'd0);
    check("rr_b_idle.valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
